// File: rtl/bypass_select_controller_pkg.sv
// Bypass control types shared by the select controller and its operand matchers.
package bypass_select_controller_pkg;

   localparam int BYP_INT_LANES    = 2;
   localparam int BYP_MEM_LANES    = 2;
   localparam int BYP_CONS_LANES   = 4;
   localparam int BYP_PREG_W       = 7;
   localparam int BYPASS_STAGE_NUM = 4;

   localparam int INT_LANE_W     = (BYP_INT_LANES > 1) ? $clog2(BYP_INT_LANES) : 1;
   localparam int MEM_LANE_W     = (BYP_MEM_LANES > 1) ? $clog2(BYP_MEM_LANES) : 1;
   localparam int COMPLEX_LANE_W = 1;

   typedef enum logic [$clog2(BYPASS_STAGE_NUM)-1:0] {
      BYPASS_STAGE_INT_EX,
      BYPASS_STAGE_INT_WB,
      BYPASS_STAGE_MEM_MA,
      BYPASS_STAGE_MEM_WB
   } BypassStage;

   typedef struct packed {
      logic [INT_LANE_W-1:0]     intLane;
      logic [MEM_LANE_W-1:0]     memLane;
      logic [COMPLEX_LANE_W-1:0] complexLane;
   } BypassLane;

   typedef struct packed {
      logic       valid;
      BypassStage stg;
      BypassLane  lane;
   } BypassSelect;

   typedef struct packed {
      BypassSelect rA;
      BypassSelect rB;
   } BypassControll;

   typedef struct packed {
      logic                  valid;
      logic [BYP_PREG_W-1:0] dst;
   } BypassProducerEntry;

   // INT stages fill only intLane, MEM stages only memLane; complexLane stays 0.
   function automatic BypassLane bypass_lane_enc(input BypassStage st, input int idx);
      BypassLane l;
      l = '0;
      if (st == BYPASS_STAGE_INT_EX || st == BYPASS_STAGE_INT_WB)
         l.intLane = idx[INT_LANE_W-1:0];
      else
         l.memLane = idx[MEM_LANE_W-1:0];
      return l;
   endfunction

endpackage

// File: rtl/bypass_operand_matcher.sv
// One operand's compare against all producer candidates, priority-encoded to a BypassSelect.
module bypass_operand_matcher
   import bypass_select_controller_pkg::*;
#(
   parameter int                INT_LANES = BYP_INT_LANES,
   parameter int                MEM_LANES = BYP_MEM_LANES,
   parameter int                PREG_W    = BYP_PREG_W,
   parameter logic [PREG_W-1:0] ZERO_PREG = '0
) (
   input  logic                              use_op,
   input  logic [PREG_W-1:0]                 src,
   input  logic [INT_LANES-1:0][PREG_W:0]    int_ex,
   input  logic [INT_LANES-1:0][PREG_W:0]    int_wb,
   input  logic [MEM_LANES-1:0][PREG_W:0]    mem_ma,
   input  logic [MEM_LANES-1:0][PREG_W:0]    mem_wb,
   output logic [$bits(BypassSelect)-1:0]    sel
);

   function automatic BypassSelect mk_sel(input BypassStage st, input int idx);
      mk_sel = '{valid: 1'b1, stg: st, lane: bypass_lane_enc(st, idx)};
   endfunction

   BypassSelect s;

   always_comb begin
      s = '0;
      if (use_op && src != ZERO_PREG) begin
         // Oldest stage first, highest lane first: later hits overwrite, so the
         // youngest stage and lowest lane index end up selected.
         for (int i = MEM_LANES-1; i >= 0; i--)
            if (mem_wb[i][PREG_W] && mem_wb[i][PREG_W-1:0] == src) s = mk_sel(BYPASS_STAGE_MEM_WB, i);
         for (int i = INT_LANES-1; i >= 0; i--)
            if (int_wb[i][PREG_W] && int_wb[i][PREG_W-1:0] == src) s = mk_sel(BYPASS_STAGE_INT_WB, i);
         for (int i = MEM_LANES-1; i >= 0; i--)
            if (mem_ma[i][PREG_W] && mem_ma[i][PREG_W-1:0] == src) s = mk_sel(BYPASS_STAGE_MEM_MA, i);
         for (int i = INT_LANES-1; i >= 0; i--)
            if (int_ex[i][PREG_W] && int_ex[i][PREG_W-1:0] == src) s = mk_sel(BYPASS_STAGE_INT_EX, i);
      end
   end

   assign sel = s;

endmodule

// File: rtl/bypass_select_controller.sv
// Tracks in-flight INT/MEM destinations and registers per-operand bypass selects for EX.
module bypass_select_controller
   import bypass_select_controller_pkg::*;
#(
   parameter int                INT_LANES  = BYP_INT_LANES,
   parameter int                MEM_LANES  = BYP_MEM_LANES,
   parameter int                CONS_LANES = BYP_CONS_LANES,
   parameter int                PREG_W     = BYP_PREG_W,
   parameter logic [PREG_W-1:0] ZERO_PREG  = '0
) (
   input  logic                                         clk,
   input  logic                                         rst_n,
   input  logic                                         stall,
   input  logic                                         flush,
   input  logic [INT_LANES-1:0]                         intIssValid,
   input  logic [INT_LANES*PREG_W-1:0]                  intIssDst,
   input  logic [MEM_LANES-1:0]                         memIssValid,
   input  logic [MEM_LANES*PREG_W-1:0]                  memIssDst,
   input  logic [CONS_LANES-1:0]                        consValid,
   input  logic [CONS_LANES*PREG_W-1:0]                 consSrcA,
   input  logic [CONS_LANES*PREG_W-1:0]                 consSrcB,
   input  logic [CONS_LANES-1:0]                        consSrcAUse,
   input  logic [CONS_LANES-1:0]                        consSrcBUse,
   output logic [CONS_LANES*$bits(BypassControll)-1:0]  bypassCtrl
);

   // Only EX_int and MA_mem are kept: next cycle's WB stages hold exactly what
   // these hold now, so no later stage is ever a match candidate.
   BypassProducerEntry [INT_LANES-1:0] int_iss, ex_q;
   BypassProducerEntry [MEM_LANES-1:0] mem_iss, ma_q;
   BypassControll [CONS_LANES-1:0]     ctrl_d, ctrl_q;

   always_comb begin
      for (int i = 0; i < INT_LANES; i++)
         int_iss[i] = {intIssValid[i], intIssDst[i*PREG_W +: PREG_W]};
      for (int i = 0; i < MEM_LANES; i++)
         mem_iss[i] = {memIssValid[i], memIssDst[i*PREG_W +: PREG_W]};
   end

   for (genvar c = 0; c < CONS_LANES; c++) begin : g_cons
      BypassProducerEntry [INT_LANES-1:0] ex_cand;
      logic [$bits(BypassSelect)-1:0]     sel_a, sel_b;

      // A consumer never sees the producer issued on its own lane index this cycle.
      always_comb begin
         ex_cand = int_iss;
         for (int i = 0; i < INT_LANES; i++)
            if (i == c) ex_cand[i].valid = 1'b0;
      end

      bypass_operand_matcher #(
         .INT_LANES(INT_LANES), .MEM_LANES(MEM_LANES), .PREG_W(PREG_W), .ZERO_PREG(ZERO_PREG)
      ) u_ra (
         .use_op (consValid[c] & consSrcAUse[c]),
         .src    (consSrcA[c*PREG_W +: PREG_W]),
         .int_ex (ex_cand),
         .int_wb (ex_q),
         .mem_ma (mem_iss),
         .mem_wb (ma_q),
         .sel    (sel_a)
      );

      bypass_operand_matcher #(
         .INT_LANES(INT_LANES), .MEM_LANES(MEM_LANES), .PREG_W(PREG_W), .ZERO_PREG(ZERO_PREG)
      ) u_rb (
         .use_op (consValid[c] & consSrcBUse[c]),
         .src    (consSrcB[c*PREG_W +: PREG_W]),
         .int_ex (ex_cand),
         .int_wb (ex_q),
         .mem_ma (mem_iss),
         .mem_wb (ma_q),
         .sel    (sel_b)
      );

      assign ctrl_d[c] = {sel_a, sel_b};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q   <= '0;
         ma_q   <= '0;
         ctrl_q <= '0;
      end else if (flush) begin
         ex_q   <= '0;
         ma_q   <= '0;
         ctrl_q <= '0;
      end else if (!stall) begin
         ex_q   <= int_iss;
         ma_q   <= mem_iss;
         ctrl_q <= ctrl_d;
      end
   end

   assign bypassCtrl = ctrl_q;

endmodule

// File: tb/tb_bypass_select_controller.sv
// Directed vector table, stall/flush/reset sequences and random traffic against a reference model.
module tb_bypass_select_controller;

   logic        clk, rst_n, stall, flush;
   logic [1:0]  intIssValid, memIssValid;
   logic [13:0] intIssDst, memIssDst;
   logic [3:0]  consValid, consSrcAUse, consSrcBUse;
   logic [27:0] consSrcA, consSrcB;
   logic [47:0] bypassCtrl;

   bypass_select_controller dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
      .intIssValid(intIssValid), .intIssDst(intIssDst),
      .memIssValid(memIssValid), .memIssDst(memIssDst),
      .consValid(consValid), .consSrcA(consSrcA), .consSrcB(consSrcB),
      .consSrcAUse(consSrcAUse), .consSrcBUse(consSrcBUse),
      .bypassCtrl(bypassCtrl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: producers that occupy EX_int / MA_mem, and the expected output word.
   bit          mex_v[2], mma_v[2];
   int          mex_d[2], mma_d[2];
   logic [47:0] exp_ctrl;

   typedef struct {
      string name;
      int iv, id0, id1, mv, md0, md1, cl, sa, ua, sb, ub, ea, eb;
   } vec_t;
   vec_t vt[12];

   task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   // Select word: valid*32 + stage*8 + intLane*4 + memLane*2; candidates searched youngest first.
   function automatic logic [5:0] ref_sel(input int c, input bit en, input int src);
      if (!en || src == 0) return 6'd0;
      for (int i = 0; i < 2; i++)
         if (intIssValid[i] && i != c && int'(intIssDst[i*7 +: 7]) == src) return 6'(32 + 0 + 4*i);
      for (int i = 0; i < 2; i++)
         if (memIssValid[i] && int'(memIssDst[i*7 +: 7]) == src) return 6'(32 + 16 + 2*i);
      for (int i = 0; i < 2; i++)
         if (mex_v[i] && mex_d[i] == src) return 6'(32 + 8 + 4*i);
      for (int i = 0; i < 2; i++)
         if (mma_v[i] && mma_d[i] == src) return 6'(32 + 24 + 2*i);
      return 6'd0;
   endfunction

   function automatic logic [47:0] pk(input int c, input int a, input int b);
      logic [47:0] r;
      r = '0;
      r[c*12 +: 12] = {6'(a), 6'(b)};
      return r;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 2; i++) begin
         mex_v[i] = 0; mma_v[i] = 0; mex_d[i] = 0; mma_d[i] = 0;
      end
      exp_ctrl = '0;
   endtask

   task automatic clr_in();
      stall = 0; flush = 0;
      intIssValid = '0; intIssDst = '0; memIssValid = '0; memIssDst = '0;
      consValid = '0; consSrcA = '0; consSrcB = '0; consSrcAUse = '0; consSrcBUse = '0;
   endtask

   task automatic tick();
      logic [47:0] nxt;
      nxt = exp_ctrl;
      if (flush) begin
         model_clear();
         nxt = '0;
      end else if (!stall) begin
         for (int c = 0; c < 4; c++)
            nxt[c*12 +: 12] = {ref_sel(c, consValid[c] && consSrcAUse[c], int'(consSrcA[c*7 +: 7])),
                               ref_sel(c, consValid[c] && consSrcBUse[c], int'(consSrcB[c*7 +: 7]))};
         for (int i = 0; i < 2; i++) begin
            mex_v[i] = intIssValid[i]; mex_d[i] = int'(intIssDst[i*7 +: 7]);
            mma_v[i] = memIssValid[i]; mma_d[i] = int'(memIssDst[i*7 +: 7]);
         end
      end
      @(posedge clk); #1;
      exp_ctrl = nxt;
      chk("model", bypassCtrl, exp_ctrl);
   endtask

   function automatic vec_t mk(input string n, input int iv, input int id0, input int id1,
                               input int mv, input int md0, input int md1, input int cl,
                               input int sa, input int ua, input int sb, input int ub,
                               input int ea, input int eb);
      vec_t v;
      v.name = n; v.iv = iv; v.id0 = id0; v.id1 = id1; v.mv = mv; v.md0 = md0; v.md1 = md1;
      v.cl = cl; v.sa = sa; v.ua = ua; v.sb = sb; v.ub = ub; v.ea = ea; v.eb = eb;
      return v;
   endfunction

   task automatic apply(input vec_t v);
      clr_in();
      intIssValid = 2'(v.iv);
      intIssDst   = {7'(v.id1), 7'(v.id0)};
      memIssValid = 2'(v.mv);
      memIssDst   = {7'(v.md1), 7'(v.md0)};
      consValid[v.cl]        = 1'b1;
      consSrcA[v.cl*7 +: 7]  = 7'(v.sa);
      consSrcB[v.cl*7 +: 7]  = 7'(v.sb);
      consSrcAUse[v.cl]      = v.ua[0];
      consSrcBUse[v.cl]      = v.ub[0];
   endtask

   initial begin
      //           name            iv id0 id1 mv md0 md1 cl  sa ua  sb ub  ea     eb
      vt[0]  = mk("int_issue",     2,  0, 12, 0,  0,  0, 0,  0, 0,  0, 0, 0,     0);
      vt[1]  = mk("int_wb",        0,  0,  0, 0,  0,  0, 0, 12, 1,  0, 0, 'h2C,  0);
      vt[2]  = mk("back_to_back",  1,  5,  0, 0,  0,  0, 1,  0, 0,  5, 1, 0,     'h20);
      vt[3]  = mk("same_lane",     1,  7,  0, 0,  0,  0, 0,  7, 1,  5, 1, 0,     'h28);
      vt[4]  = mk("intex_over_ma", 1,  9,  0, 2,  0,  9, 2,  9, 1,  7, 1, 'h20,  'h28);
      vt[5]  = mk("intwb_over_mw", 1, 21,  0, 2,  0, 20, 3,  9, 1, 20, 1, 'h28,  'h32);
      vt[6]  = mk("mem_wb",        0,  0,  0, 0,  0,  0, 1, 20, 1, 21, 1, 'h3A,  'h28);
      vt[7]  = mk("zero_unused",   1,  0,  0, 1, 33,  0, 2,  0, 1, 33, 0, 0,     0);
      vt[8]  = mk("zero_wb",       0,  0,  0, 0,  0,  0, 3,  0, 1, 33, 1, 0,     'h38);
      vt[9]  = mk("lowest_lane",   3, 40, 40, 3, 41, 41, 3, 40, 1, 41, 1, 'h20,  'h30);
      vt[10] = mk("lowest_wb",     0,  0,  0, 0,  0,  0, 0, 40, 1, 41, 1, 'h28,  'h38);
      vt[11] = mk("excl_lane1",    2,  0, 50, 0,  0,  0, 1, 50, 1, 50, 1, 0,     0);

      clr_in();
      model_clear();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset", bypassCtrl, 48'd0);
      rst_n = 1'b1;

      foreach (vt[k]) begin
         apply(vt[k]);
         tick();
         chk(vt[k].name, bypassCtrl, pk(vt[k].cl, vt[k].ea, vt[k].eb));
      end

      // Stall: output and EX contents frozen for 3 cycles despite new inputs.
      apply(mk("", 1, 61, 0, 0, 0, 0, 2, 50, 1, 0, 0, 0, 0));
      tick();
      chk("stall_setup", bypassCtrl, pk(2, 'h2C, 0));
      for (int s = 0; s < 3; s++) begin
         apply(mk("", 3, 70, 71, 3, 72, 73, 3, 61, 1, 70, 1, 0, 0));
         stall = 1'b1;
         tick();
         chk("stall_hold", bypassCtrl, pk(2, 'h2C, 0));
      end
      apply(mk("", 0, 0, 0, 0, 0, 0, 3, 61, 1, 0, 0, 0, 0));
      tick();
      chk("stall_release", bypassCtrl, pk(3, 'h28, 0));

      // Flush together with stall wipes in-flight producers.
      apply(mk("", 1, 80, 0, 1, 81, 0, 2, 80, 1, 81, 1, 0, 0));
      tick();
      chk("flush_setup", bypassCtrl, pk(2, 'h20, 'h30));
      apply(mk("", 0, 0, 0, 0, 0, 0, 0, 80, 1, 81, 1, 0, 0));
      flush = 1'b1;
      stall = 1'b1;
      tick();
      chk("flush_stall", bypassCtrl, 48'd0);
      apply(mk("", 0, 0, 0, 0, 0, 0, 2, 80, 1, 81, 1, 0, 0));
      tick();
      chk("post_flush", bypassCtrl, 48'd0);

      // Reset mid-cycle clears the output without waiting for an edge.
      apply(mk("", 1, 90, 0, 0, 0, 0, 3, 90, 1, 0, 0, 0, 0));
      tick();
      chk("reset_setup", bypassCtrl, pk(3, 'h20, 0));
      apply(mk("", 0, 0, 0, 0, 0, 0, 3, 90, 1, 0, 0, 0, 0));
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset", bypassCtrl, 48'd0);
      model_clear();
      @(posedge clk); #1;
      rst_n = 1'b1;
      apply(mk("", 0, 0, 0, 0, 0, 0, 3, 90, 1, 0, 0, 0, 0));
      tick();
      chk("post_reset", bypassCtrl, 48'd0);

      // Random traffic over a small preg range so matches and collisions are frequent.
      for (int n = 0; n < 400; n++) begin
         clr_in();
         stall = ($urandom_range(0, 9) == 0);
         flush = ($urandom_range(0, 19) == 0);
         for (int i = 0; i < 2; i++) begin
            intIssValid[i]     = 1'($urandom_range(0, 1));
            intIssDst[i*7 +: 7] = 7'($urandom_range(0, 7));
            memIssValid[i]     = 1'($urandom_range(0, 1));
            memIssDst[i*7 +: 7] = 7'($urandom_range(0, 7));
         end
         for (int c = 0; c < 4; c++) begin
            consValid[c]       = 1'($urandom_range(0, 1));
            consSrcAUse[c]     = 1'($urandom_range(0, 1));
            consSrcBUse[c]     = 1'($urandom_range(0, 1));
            consSrcA[c*7 +: 7] = 7'($urandom_range(0, 7));
            consSrcB[c*7 +: 7] = 7'($urandom_range(0, 7));
         end
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
